data_sram_arbiter: RTL
======================

# data_sram_arbiter

Shares one single-port 32x1024 data SRAM macro (1RW, active-low chip select and write enable, registered read data) among NUM_REQ requesters. It zero-fills the macro after reset or on request, then grants one access per cycle with round-robin fairness. Read data returns one cycle after the read is accepted. It sits between the solver datapath's load/store clients and the data SRAM instance, and is the only block that drives the macro pins.

## Interface
- NUM_REQ, 2: number of requesters, 2..4
- DATA_WIDTH, 32: SRAM word width
- ADDR_WIDTH, 10: SRAM address width; depth = 1<<ADDR_WIDTH
- clk0  in  1  clock; all state on posedge
- rst0  in  1  reset, asynchronous, active-high
- clear_req  in  1  pulse: re-run zero-fill (honoured only in RUN)
- init_done  out  1  high in RUN; low during INIT and reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant; request accepted when valid&ready
- req_we  in  NUM_REQ  1 = write, 0 = read (active-high)
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened, same packing
- rsp_valid  out  NUM_REQ  one-hot, read data valid for requester i
- rsp_rdata  out  DATA_WIDTH  shared read data, meaningful only when rsp_valid != 0
- mem_csb0, mem_web0  out  1 each  to macro, active-low
- mem_addr0  out  ADDR_WIDTH;  mem_din0  out  DATA_WIDTH;  mem_dout0  in  DATA_WIDTH

## Operation
- States: INIT (zero-fill) and RUN. Reset enters INIT with fill counter = 0 and RR pointer = 0.
- INIT: each cycle drives csb0=0, web0=0, addr0=counter, din0=0. Counter increments. After the write to address depth-1, the state becomes RUN, so init_done rises the cycle after the last fill write. req_ready is 0 throughout INIT.
- RUN arbitration: search req_valid from pointer p upward, modulo NUM_REQ. The first set bit i gets req_ready[i]=1. All other ready bits are 0.
- The pointer updates to (i+1) mod NUM_REQ only on a grant. With no valid request, the pointer holds and csb0=1.
- req_ready is combinational from req_valid. Requesters must not gate valid on ready. Address and data must be held stable while valid and not ready.
- Granted access drives csb0=0, web0=~req_we[i], addr0 and din0 from requester i.
- Read grant: the rsp_valid[i] register sets for exactly one cycle. Writes produce no response.
- rsp_rdata = mem_dout0, passed through with no extra register. The macro holds dout on non-read cycles.
- clear_req in RUN has priority over all requests in that cycle: no grant, state becomes INIT, counter = 0. A read granted in the preceding cycle still returns its rsp_valid normally.
- clear_req during INIT is ignored; the fill does not restart.
- Read-after-write to the same address in consecutive cycles returns the new data, because the macro writes at the edge before the read.

## Timing
- Reset values: init_done=0, req_ready=0, rsp_valid=0, mem_csb0=1, mem_web0=1, mem_addr0=0, mem_din0=0.
- Macro pins are combinational from registered state and req_* inputs and are sampled by the macro at the next posedge.
- Read latency: accepted at edge N, rsp_valid and rsp_rdata valid during cycle N+1. Back-to-back reads give one response per cycle.
- Throughput: one access per cycle. Worst-case wait for a continuously valid requester is NUM_REQ-1 grants.
- INIT lasts exactly 1<<ADDR_WIDTH cycles (1024 by default).
- Reset asserted mid-INIT or mid-RUN: all outputs return to reset values immediately. Any in-flight response is dropped, and the fill restarts from address 0 after release.

## Structure
- Shared package or header holds the state encodings (ST_INIT, ST_RUN) and the default DATA_WIDTH/ADDR_WIDTH values shared with the SRAM wrapper.
- One sub-module, rr_arbiter: NUM_REQ request vector plus pointer in; one-hot grant and next pointer out. It is reused for the CTRL SRAM controller.
- Top level holds the FSM, fill counter, pointer register, response register and pin muxing.

## Test plan
- Reset release: count exactly 1024 write cycles with din=0 at addresses 0..1023, then init_done=1. A backdoor read of address 1023 returns 0.
- Single requester: write 0xDEADBEEF to address 0x155, then read 0x155 next cycle -> rsp_valid[0] two cycles after the write grant, rsp_rdata=0xDEADBEEF.
- NUM_REQ=3, all valid continuously -> grants cycle 0,1,2,0,1,2. Remove requester 1 -> grants alternate 2,0.
- Read granted in the same cycle clear_req is raised the next cycle -> response still delivered, no grant during clear, init_done falls, and 1024 fill cycles follow.
- rst0 asserted for 1 cycle mid-RUN with a read outstanding -> rsp_valid=0 and csb0=1 immediately, followed by a full refill.
- Stress: random valid/we/addr on all requesters against a reference memory model -> all read data matches, no lost or duplicated responses.

Source files
------------

// File: rtl/data_sram_arbiter_pkg.sv
// Shared definitions for the data SRAM arbiter and its SRAM wrapper:
// FSM encodings, default macro geometry and a pointer-width helper.
package data_sram_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_sram_arbiter_rr.sv
// Round-robin arbiter: searches the request vector upward from the pointer
// (modulo N) and returns a one-hot grant plus the pointer after that grant.
module rr_arbiter
  import data_sram_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] next_ptr_o
);

  logic found;
  int   idx;

  // With no request the pointer is returned unchanged so the caller can hold it.
  always_comb begin
    gnt_o      = '0;
    next_ptr_o = ptr_i;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        next_ptr_o = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/data_sram_arbiter.sv
// Single-port data SRAM arbiter: zero-fills the macro after reset or clear,
// then grants one request per cycle round-robin and returns read responses.
module data_sram_arbiter
  import data_sram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                          clk0,
  input  logic                          rst0,
  input  logic                          clear_req,
  output logic                          init_done,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_csb0,
  output logic                          mem_web0,
  output logic [ADDR_WIDTH-1:0]         mem_addr0,
  output logic [DATA_WIDTH-1:0]         mem_din0,
  input  logic [DATA_WIDTH-1:0]         mem_dout0,
  output state_t                        dbg_state_o
);

  localparam int PW = ptr_width(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  // Handshake: a request is accepted on a clock edge where req_valid[i] and
  // req_ready[i] are both high; ready depends on valid, never the reverse.
  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [PW-1:0]          arb_next;
  logic [NUM_REQ-1:0]     grant;
  logic                   csb, web;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req_i      (req_valid),
    .ptr_i      (ptr_q),
    .gnt_o      (arb_gnt),
    .next_ptr_o (arb_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    rsp_valid_d = '0;
    grant       = '0;
    csb         = 1'b1;
    web         = 1'b1;
    addr        = '0;
    din         = '0;
    // Pins are forced idle while reset is held so the macro sees no access.
    if (!rst0) begin
      case (state_q)
        ST_INIT: begin
          csb   = 1'b0;
          web   = 1'b0;
          addr  = cnt_q;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (clear_req) begin
            state_d = ST_INIT;
            cnt_d   = '0;
          end else if (|arb_gnt) begin
            grant       = arb_gnt;
            ptr_d       = arb_next;
            csb         = 1'b0;
            rsp_valid_d = arb_gnt & ~req_we;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (arb_gnt[i]) begin
                web  = ~req_we[i];
                addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                din  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
              end
            end
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign init_done   = (state_q == ST_RUN);
  assign req_ready   = grant;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = mem_dout0;
  assign mem_csb0    = csb;
  assign mem_web0    = web;
  assign mem_addr0   = addr;
  assign mem_din0    = din;
  assign dbg_state_o = state_q;

endmodule
